// File: rtl/mem_latency_bridge_pkg.sv
// Shared definitions for the memory latency bridge: FSM state encoding and
// the width of the saturating rejected-request counter.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/mem_latency_bridge_if.sv
// Bus bundle between requester, bridge and behavioural memory.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. The requester holds req_valid and its payload
// (req_wen, req_addr, req_wdata) stable until that edge. resp_valid is a
// single-cycle pulse with no backpressure; resp_rdata/resp_err are only
// meaningful while resp_valid is high. mem_q is combinational from mem_a.
interface mem_latency_bridge_if #(
  parameter int BITS = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [BITS-1:0] req_addr;
  logic [BITS-1:0] req_wdata;
  logic            resp_valid;
  logic [BITS-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_wen;
  logic [BITS-1:0] mem_a;
  logic [BITS-1:0] mem_d;
  logic [BITS-1:0] mem_q;

  // Bridge side.
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, mem_q,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_wen, mem_a, mem_d
  );

  // Environment side: requester plus the memory model.
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, mem_q,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_wen, mem_a, mem_d
  );
endinterface

// File: rtl/mem_latency_bridge.sv
// Single-outstanding request bridge that delays each accepted load/store by
// LATENCY cycles before a one-cycle access to a word-addressed memory, then
// returns a one-cycle response. Out-of-range or misaligned requests are
// rejected without touching memory and counted in a saturating counter.
module mem_latency_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          BITS    = 32,
  parameter int          LATENCY = 4,
  parameter int unsigned BASE    = 0,
  parameter int          WORDS   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_latency_bridge_if.slave  bus,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output state_t               dbg_state
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("mem_latency_bridge: LATENCY must be at least 1");
  end

  localparam int CNT_W = $clog2(LATENCY) + 1;
  // Window bounds kept one bit wider than the address so BASE+4*WORDS
  // cannot wrap past the top of the address space.
  localparam logic [BITS:0]      MEM_LO      = (BITS+1)'(BASE);
  localparam logic [BITS:0]      MEM_HI      = MEM_LO + ((BITS+1)'(WORDS) << 2);
  localparam logic [CNT_W-1:0]   CNT_LOAD    = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BITS-1:0]       addr_q, addr_d;
  logic [BITS-1:0]       wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [BITS-1:0]       resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  mem_wen_q, mem_wen_d;

  logic [BITS:0]         addr_ext;
  logic                  req_err;
  logic                  accept;

  // Classify the incoming request as rejected or serviceable.
  always_comb begin
    addr_ext = {1'b0, bus.req_addr};
    req_err  = (bus.req_addr[1:0] != 2'b00) || (addr_ext < MEM_LO) || (addr_ext >= MEM_HI);
    accept   = bus.req_valid && req_ready_q;
  end

  // Next-state and next-output computation; outputs are derived from the
  // next state so every port is driven straight from a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    err_d        = err_q;
    resp_rdata_d = resp_rdata_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wen_d   = bus.req_wen;
          err_d   = req_err;
          if (req_err) begin
            state_d      = RESP;
            resp_rdata_d = '0;
            if (err_cnt_q != ERR_CNT_MAX) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
          end else if (LATENCY == 1) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_rdata_d = wen_q ? '0 : bus.mem_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = (state_d == RESP) && err_d;
    mem_wen_d    = (state_d == ACCESS) && wen_d;
  end

  // State and output registers; async reset drops any pending request and
  // pulls mem_wen low without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      err_cnt_q    <= '0;
      mem_wen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      err_cnt_q    <= err_cnt_d;
      mem_wen_q    <= mem_wen_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_a      = addr_q;
  assign bus.mem_d      = wdata_q;
  assign err_cnt        = err_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_latency_bridge.sv
// Bench for mem_latency_bridge: three bridge instances with different
// LATENCY/BASE settings, each with its own behavioural memory. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mem_latency_bridge;
  import mem_bridge_pkg::*;

  localparam int          NI        = 3;
  localparam int          LAT_P [3] = '{4, 1, 2};
  localparam int unsigned BASE_P[3] = '{32'h0, 32'h0, 32'h1000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- per-instance drive / monitor ----------------
  logic        drv_valid [NI];
  logic        drv_wen   [NI];
  logic [31:0] drv_addr  [NI];
  logic [31:0] drv_wdata [NI];
  logic        mon_ready [NI];
  logic        mon_rvalid[NI];
  logic        mon_err   [NI];
  logic        mon_mwen  [NI];
  logic [31:0] mon_rdata [NI];
  logic [31:0] mon_mema  [NI];
  logic [31:0] mon_memd  [NI];
  logic [7:0]  mon_errcnt[NI];
  state_t      mon_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    mem_latency_bridge_if #(.BITS(32)) bus ();
    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] off;

    assign off            = bus.mem_a - BASE_P[g];
    assign bus.mem_q      = mem[off[6:2]];
    assign bus.req_valid  = drv_valid[g];
    assign bus.req_wen    = drv_wen[g];
    assign bus.req_addr   = drv_addr[g];
    assign bus.req_wdata  = drv_wdata[g];
    assign mon_ready[g]   = bus.req_ready;
    assign mon_rvalid[g]  = bus.resp_valid;
    assign mon_err[g]     = bus.resp_err;
    assign mon_mwen[g]    = bus.mem_wen;
    assign mon_rdata[g]   = bus.resp_rdata;
    assign mon_mema[g]    = bus.mem_a;
    assign mon_memd[g]    = bus.mem_d;

    always @(posedge clk) begin
      if (bus.mem_wen) mem[off[6:2]] <= bus.mem_d;
    end

    mem_latency_bridge #(
      .BITS(32), .LATENCY(LAT_P[g]), .BASE(BASE_P[g]), .WORDS(32)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_cnt   (mon_errcnt[g]),
      .dbg_state (mon_state[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request at the current falling edge (cycle 0) and watch the
  // instance until its response pulse.
  task automatic run_txn(input int inst, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, output int resp_cyc,
                         output int mwen_cyc, output int mwen_n,
                         output logic [31:0] rdata, output logic err);
    resp_cyc = -1; mwen_cyc = -1; mwen_n = 0; rdata = '0; err = 1'b0;
    check($sformatf("i%0d_ready_before_req", inst), 32'(mon_ready[inst]), 32'd1);
    drv_valid[inst] = 1'b1;
    drv_wen[inst]   = wen;
    drv_addr[inst]  = addr;
    drv_wdata[inst] = wdata;
    for (int c = 1; c <= 20 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) drv_valid[inst] = 1'b0;
      if (mon_mwen[inst]) begin
        mwen_n++;
        if (mwen_cyc < 0) mwen_cyc = c;
      end
      if (mon_rvalid[inst]) begin
        resp_cyc = c;
        rdata    = mon_rdata[inst];
        err      = mon_err[inst];
      end
    end
    @(negedge clk);
    check($sformatf("i%0d_resp_one_cycle", inst), 32'(mon_rvalid[inst]), 32'd0);
  endtask

  // Present request A in cycle 0 and, from cycle b_start, hold request B until
  // accepted. Records per-cycle ready/mem_wen/resp_valid bitmasks.
  task automatic run_pair(input int inst,
                          input logic a_wen, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                          input logic b_wen, input logic [31:0] b_addr, input logic [31:0] b_wdata,
                          input int b_start, input int ncyc,
                          output logic [31:0] ready_m, output logic [31:0] mwen_m,
                          output logic [31:0] rvalid_m, output int b_acc,
                          output logic [31:0] rdata_a, output logic [31:0] rdata_b);
    int rcount;
    ready_m = '0; mwen_m = '0; rvalid_m = '0; b_acc = -1;
    rdata_a = 32'hFFFF_FFFF; rdata_b = 32'hFFFF_FFFF; rcount = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      if (mon_ready[inst])  ready_m[c] = 1'b1;
      if (mon_mwen[inst])   mwen_m[c]  = 1'b1;
      if (mon_rvalid[inst]) begin
        rvalid_m[c] = 1'b1;
        if (rcount == 0) rdata_a = mon_rdata[inst];
        else             rdata_b = mon_rdata[inst];
        rcount++;
      end
      if (c == 0) begin
        drv_valid[inst] = 1'b1; drv_wen[inst] = a_wen;
        drv_addr[inst]  = a_addr; drv_wdata[inst] = a_wdata;
      end else if (c >= b_start && b_acc < 0) begin
        drv_valid[inst] = 1'b1; drv_wen[inst] = b_wen;
        drv_addr[inst]  = b_addr; drv_wdata[inst] = b_wdata;
        if (mon_ready[inst]) b_acc = c;
      end else begin
        drv_valid[inst] = 1'b0;
      end
    end
    drv_valid[inst] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          inst;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          resp_cyc, mwen_cyc, mwen_n, b_acc;
    logic [31:0] rdata, rdata_a, rdata_b, ready_m, mwen_m, rvalid_m;
    logic        err, seen_mwen, seen_rvalid;

    vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{0, 1'b1, 32'h0000_007C, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vecs[3]  = '{0, 1'b0, 32'h0000_007C, 32'h0,         1'b0, 32'h1234_5678};
    vecs[4]  = '{0, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000};
    vecs[5]  = '{0, 1'b1, 32'h0000_0080, 32'h5555_5555, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0BAD_CAFE};
    vecs[7]  = '{1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_0000};
    vecs[8]  = '{2, 1'b1, 32'h0000_1080, 32'h7777_7777, 1'b1, 32'h0000_0000};
    vecs[9]  = '{2, 1'b1, 32'h0000_107C, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000};
    vecs[10] = '{2, 1'b0, 32'h0000_107C, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[11] = '{2, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'h0000_0000};
    vecs[12] = '{2, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[13] = '{2, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[14] = '{0, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_0001};

    for (int i = 0; i < NI; i++) begin
      drv_valid[i] = 1'b0; drv_wen[i] = 1'b0; drv_addr[i] = '0; drv_wdata[i] = '0;
    end

    // Reset values, observed while reset is still asserted and after release.
    repeat (3) @(negedge clk);
    check("rst_ready",      32'(mon_ready[0]),  32'd1);
    check("rst_resp_valid", 32'(mon_rvalid[0]), 32'd0);
    check("rst_resp_rdata", mon_rdata[0],       32'd0);
    check("rst_resp_err",   32'(mon_err[0]),    32'd0);
    check("rst_err_cnt",    32'(mon_errcnt[0]), 32'd0);
    check("rst_mem_wen",    32'(mon_mwen[0]),   32'd0);
    check("rst_mem_a",      mon_mema[0],        32'd0);
    check("rst_mem_d",      mon_memd[0],        32'd0);
    check("rst_state",      32'(mon_state[0]),  32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("i%0d_ready_after_rst", i), 32'(mon_ready[i]), 32'd1);

    // Reset during WAIT of a write: no mem_wen, no response, memory untouched.
    drv_valid[0] = 1'b1; drv_wen[0] = 1'b1; drv_addr[0] = 32'h8; drv_wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    check("wait_ready_low", 32'(mon_ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("wait_rst_ready",  32'(mon_ready[0]), 32'd1);
    check("wait_rst_mwen",   32'(mon_mwen[0]),  32'd0);
    seen_mwen = 1'b0; seen_rvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      seen_mwen   |= mon_mwen[0];
      seen_rvalid |= mon_rvalid[0];
    end
    check("wait_rst_no_mwen",  32'(seen_mwen),   32'd0);
    check("wait_rst_no_resp",  32'(seen_rvalid), 32'd0);
    run_txn(0, 1'b0, 32'h8, 32'h0, resp_cyc, mwen_cyc, mwen_n, rdata, err);
    check("wait_rst_readback", rdata, 32'd0);
    check("wait_rst_read_cyc", 32'(resp_cyc), 32'd5);

    // Reset during ACCESS: mem_wen falls without a clock edge, write is lost.
    drv_valid[0] = 1'b1; drv_wen[0] = 1'b1; drv_addr[0] = 32'h8; drv_wdata[0] = 32'h1111_1111;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("access_mwen_high", 32'(mon_mwen[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("access_mwen_async_fall", 32'(mon_mwen[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen_rvalid |= mon_rvalid[0];
    end
    check("access_rst_no_resp", 32'(seen_rvalid), 32'd0);
    run_txn(0, 1'b0, 32'h8, 32'h0, resp_cyc, mwen_cyc, mwen_n, rdata, err);
    check("access_rst_readback", rdata, 32'd0);

    // LATENCY=1 back-to-back: read then write with req_valid held.
    run_pair(1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h20, 32'h0BAD_CAFE, 1, 8,
             ready_m, mwen_m, rvalid_m, b_acc, rdata_a, rdata_b);
    check("lat1_b_accept_cyc", 32'(b_acc), 32'd3);
    check("lat1_ready_mask",   ready_m,    32'h0000_00C9);
    check("lat1_mwen_mask",    mwen_m,     32'h0000_0010);
    check("lat1_rvalid_mask",  rvalid_m,   32'h0000_0024);
    check("lat1_read_rdata",   rdata_a,    32'h0);
    check("lat1_write_rdata",  rdata_b,    32'h0);

    // Request presented while busy waits for the IDLE cycle after RESP.
    run_pair(0, 1'b1, 32'h30, 32'h1, 1'b0, 32'h30, 32'h0, 1, 13,
             ready_m, mwen_m, rvalid_m, b_acc, rdata_a, rdata_b);
    check("busy_b_accept_cyc", 32'(b_acc), 32'd6);
    check("busy_ready_mask",   ready_m,    32'h0000_1041);
    check("busy_mwen_mask",    mwen_m,     32'h0000_0010);
    check("busy_rvalid_mask",  rvalid_m,   32'h0000_0820);
    check("busy_read_rdata",   rdata_b,    32'h0000_0001);

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].inst, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
              resp_cyc, mwen_cyc, mwen_n, rdata, err);
      check($sformatf("v%0d_resp_cycle", i), 32'(resp_cyc),
            vecs[i].exp_err ? 32'd1 : 32'(LAT_P[vecs[i].inst] + 1));
      check($sformatf("v%0d_resp_err", i),   32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_resp_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mwen_pulses", i), 32'(mwen_n),
            (vecs[i].wen && !vecs[i].exp_err) ? 32'd1 : 32'd0);
      if (vecs[i].wen && !vecs[i].exp_err)
        check($sformatf("v%0d_mwen_cycle", i), 32'(mwen_cyc), 32'(LAT_P[vecs[i].inst]));
    end
    check("i0_err_cnt", 32'(mon_errcnt[0]), 32'd2);
    check("i1_err_cnt", 32'(mon_errcnt[1]), 32'd0);
    check("i2_err_cnt", 32'(mon_errcnt[2]), 32'd3);

    // 260 back-to-back misaligned requests saturate the counter at 255.
    drv_valid[1] = 1'b1; drv_wen[1] = 1'b0; drv_addr[1] = 32'h3; drv_wdata[1] = 32'h0;
    seen_mwen = 1'b0;
    for (int k = 0; k < 520; k++) begin
      @(negedge clk);
      seen_mwen |= mon_mwen[1];
      if (k == 509) check("sat_err_cnt_255_early", 32'(mon_errcnt[1]), 32'd255);
    end
    drv_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_err_cnt",  32'(mon_errcnt[1]), 32'd255);
    check("sat_no_mwen",  32'(seen_mwen),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_latency_bridge.md
# mem_latency_bridge

Request/response bridge between the core's load/store port and the word-addressed, single-cycle behavioural memory model. It accepts one transaction at a time, holds it for a programmable number of wait cycles, and performs the memory access in one cycle. It then returns read data or an error flag as a one-cycle response pulse. This lets testbenches run the core against realistic memory latency without changing the memory model.

## Interface
- BITS, 32, data and address width
- LATENCY, 4, cycles from request acceptance to the memory access cycle; must be ≥1, elaboration error otherwise
- BASE, 0, byte address of word 0 of the attached memory
- WORDS, 32, number of words in the attached memory
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_wen  in  1  request type: 0 read, 1 write
- req_addr  in  BITS  request byte address
- req_wdata  in  BITS  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  BITS  read data, valid with resp_valid on reads
- resp_err  out  1  request rejected, valid with resp_valid
- err_cnt  out  8  count of rejected requests, saturating
- mem_wen  out  1  memory write enable
- mem_a  out  BITS  memory address
- mem_d  out  BITS  memory write data
- mem_q  in  BITS  memory read data, combinational from mem_a

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1, all other outputs inactive.
  - On req_valid&&req_ready, capture addr, wdata and wen into registers.
  - Evaluate the error condition: req_addr[1:0]!=0, or req_addr<BASE, or req_addr≥BASE+4*WORDS. Compute the upper bound in BITS+1 bits, with no wrap.
  - Error → RESP with err set; no memory access, no write.
  - No error and LATENCY=1 → ACCESS.
  - No error and LATENCY>1 → WAIT with counter loaded to LATENCY-2.
- WAIT: counter decrements each cycle; at 0 → ACCESS.
- ACCESS:
  - Exactly one cycle.
  - mem_wen = captured wen.
  - On the closing edge, the memory commits the write; on reads, mem_q is registered into resp_rdata. → RESP.
- RESP:
  - resp_valid=1 for one cycle, then → IDLE.
  - resp_rdata is 0 on writes and errors.
  - resp_err is 1 on errors.
  - err_cnt increments, saturating at 255.
- mem_a and mem_d always reflect the captured registers; mem_wen is high only in ACCESS.
- req_ready=0 outside IDLE. The requester must hold its request until accepted; a request presented while busy is neither dropped nor queued by the bridge.
- Responses are not backpressured.

## Timing
- Reset (async): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, err_cnt=0, mem_wen=0, mem_a=0, mem_d=0, counter=0.
- Reset mid-transaction: the pending request is dropped with no response. mem_wen falls immediately, without waiting for a clock edge.
- Cycle numbering: cycle 0 is the acceptance cycle.
  - ACCESS occurs in cycle LATENCY.
  - resp_valid is high in cycle LATENCY+1.
  - Errors: resp_valid is high in cycle 1.
- Back-to-back throughput: with req_valid held, the next acceptance is cycle LATENCY+2, giving one transaction per LATENCY+2 cycles. An error request takes 2 cycles.
- resp_rdata holds its value until the next RESP or reset.

## Structure
- Shared package mem_bridge_pkg: state enum (IDLE/WAIT/ACCESS/RESP) and the error-count width constant (8).
- Single module, no sub-modules.
- The counter width is $clog2(LATENCY)+1, local to the module.

## Test plan
- Reset during WAIT of a write to 0x8 → mem_wen never pulses; after release, a read of 0x8 returns 0; no resp_valid is seen for the dropped request.
- LATENCY=4, BASE=0: write 0xDEADBEEF to 0x10 accepted in cycle 0 → mem_wen=1 only in cycle 4, resp_valid in cycle 5. Then read 0x10 → resp_rdata=0xDEADBEEF, resp_err=0.
- LATENCY=1: read then write with req_valid held → acceptances 3 cycles apart, ACCESS in cycle 1 of each.
- Misaligned read of 0x6 → resp_valid in cycle 1 with resp_err=1, no mem_wen, err_cnt=1.
- BASE=0x1000, WORDS=32: write to 0x1080 (one past end) → err. Write to 0x107C → succeeds and reads back.
- 260 error requests → err_cnt saturates at 255.
- req_valid asserted during WAIT → req_ready stays 0; the request is accepted only in the IDLE cycle after RESP.
